// File: rtl/multi_channel_sample_voter.sv
// Multi-channel oversampling bit voter: each channel synchronises its serial line,
// samples the middle of every bit period and issues one voted bit per period.
module multi_channel_sample_voter #(
  parameter int unsigned CHANNELS           = 4,
  parameter int unsigned BAUD_WIDTH         = 16,
  parameter int unsigned MULTI_SAMPLE_WIDTH = 4,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           rxd,
  input  logic [CHANNELS-1:0]           rx_enable_n,
  input  logic [BAUD_WIDTH-1:0]         clk_per_baud,
  input  logic [MULTI_SAMPLE_WIDTH-1:0] multi_sample,
  input  logic                          vote_mode,
  output logic [CHANNELS-1:0]           rx_data,
  output logic [CHANNELS-1:0]           rx,
  output logic [CHANNELS-1:0]           rx_glitch
);

  localparam int unsigned BW = BAUD_WIDTH;
  localparam int unsigned MW = MULTI_SAMPLE_WIDTH;
  localparam int unsigned CW = ((BW > MW) ? BW : MW) + 1;

  logic [BW-1:0] p_new_c;
  logic [BW-1:0] s_new_c;
  logic [MW-1:0] m_new_c;
  logic [CW-1:0] p_ext_c;
  logic [CW-1:0] m_raw_c;
  logic [CW-1:0] m_ext_c;

  // Clamped bit period, sample count and centred sample offset, shared by all channels
  always_comb begin
    p_new_c = (clk_per_baud < BW'(2)) ? BW'(2) : clk_per_baud;
    p_ext_c = CW'(p_new_c);
    m_raw_c = (multi_sample == '0) ? CW'(1) : CW'(multi_sample);
    m_ext_c = (m_raw_c > p_ext_c) ? p_ext_c : m_raw_c;
    m_new_c = MW'(m_ext_c);
    s_new_c = BW'((p_ext_c - m_ext_c) >> 1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   active_q, active_d;
    logic [BW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          p_q, p_d;
    logic [BW-1:0]          s_q, s_d;
    logic [MW-1:0]          m_q, m_d;
    logic [MW-1:0]          smp_q, smp_d;
    logic [MW:0]            ones_q, ones_d;
    logic                   data_q, data_d;
    logic                   rx_q, rx_d;
    logic                   glitch_q, glitch_d;
    logic                   sample_c;
    logic                   bit_end_c;
    logic [MW:0]            ones_tot_c;
    logic [MW+1:0]          twice_c;
    logic [MW+1:0]          m2_c;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q   <= '1;
        active_q <= 1'b0;
        cnt_q    <= '0;
        p_q      <= '0;
        s_q      <= '0;
        m_q      <= '0;
        smp_q    <= '0;
        ones_q   <= '0;
        data_q   <= 1'b1;
        rx_q     <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        active_q <= active_d;
        cnt_q    <= cnt_d;
        p_q      <= p_d;
        s_q      <= s_d;
        m_q      <= m_d;
        smp_q    <= smp_d;
        ones_q   <= ones_d;
        data_q   <= data_d;
        rx_q     <= rx_d;
        glitch_q <= glitch_d;
      end
    end

    always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], rxd[g]};
      active_d   = active_q;
      cnt_d      = cnt_q;
      p_d        = p_q;
      s_d        = s_q;
      m_d        = m_q;
      smp_d      = smp_q;
      ones_d     = ones_q;
      data_d     = data_q;
      rx_d       = 1'b0;
      glitch_d   = 1'b0;
      sample_c   = active_q && (cnt_q >= s_q) && (smp_q < m_q);
      // The final sample may land on the last cycle of the bit, so vote on the running total
      ones_tot_c = ones_q + (MW+1)'(sample_c && sync_q[SYNC_STAGES-1]);
      bit_end_c  = active_q && (cnt_q == (p_q - BW'(1)));
      twice_c    = {ones_tot_c, 1'b0};
      m2_c       = (MW+2)'(m_q);

      if (sample_c) begin
        smp_d  = smp_q + MW'(1);
        ones_d = ones_tot_c;
      end

      // A strobe already due is issued even if the enable drops on this edge
      if (bit_end_c) begin
        rx_d     = 1'b1;
        glitch_d = (ones_tot_c != '0) && (ones_tot_c != (MW+1)'(m_q));
        if (vote_mode) begin
          if (ones_tot_c == (MW+1)'(m_q)) begin
            data_d = 1'b1;
          end else if (ones_tot_c == '0) begin
            data_d = 1'b0;
          end
        end else begin
          if (twice_c > m2_c) begin
            data_d = 1'b1;
          end else if (twice_c < m2_c) begin
            data_d = 1'b0;
          end
        end
      end

      if (rx_enable_n[g]) begin
        active_d = 1'b0;
        cnt_d    = '0;
        smp_d    = '0;
        ones_d   = '0;
      end else if (!active_q || bit_end_c) begin
        active_d = 1'b1;
        cnt_d    = '0;
        smp_d    = '0;
        ones_d   = '0;
        p_d      = p_new_c;
        m_d      = m_new_c;
        s_d      = s_new_c;
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end

    assign rx_data[g]   = data_q;
    assign rx[g]        = rx_q;
    assign rx_glitch[g] = glitch_q;
  end

endmodule
